// File: rtl/wca_rbus_dword_master.sv
// ---------------------------------------------------------------------------
// wca_rbus_dword_master
//
// Host-side master for the byte-wide register bus. It accepts one 32-bit
// read or write request at a time and moves it as four byte bus cycles,
// LSB first. Each transfer is followed by GAP_CYCLES idle bus cycles so
// that slave byte selectors fall back to byte 0 before the next transfer.
//
// A bus cycle is two clocks. The phase bit ph is exported as clkbus, and
// every other bus signal changes only on the ph 1->0 edge. This keeps
// those signals stable across each clkbus rising edge.
//
// Parameters
//   IDLE_ADDR   address driven when no transfer is active (no slave owns it)
//   GAP_CYCLES  idle bus cycles after every transfer (1..3)
//
// Ports
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   req_valid  host request present
//   req_write  1 = dword write, 0 = dword read
//   req_addr   target register address
//   req_data   write data (ignored for reads)
//   req_ready  request taken when req_valid & req_ready at a clock edge
//   done       one-clock pulse when a transfer completes
//   rsp_data   assembled read data, valid while done pulses for a read
//   rbusCtrl   {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}
//   rbusData   tri-state byte bus, driven only during write bytes
// ---------------------------------------------------------------------------
module wca_rbus_dword_master #(
  parameter logic [7:0] IDLE_ADDR  = 8'hFF,
  parameter int         GAP_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic        done,
  output logic [31:0] rsp_data,
  output logic [11:0] rbusCtrl,
  inout  wire  [7:0]  rbusData
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // The gap is counted in clocks. It leaves GAP one clock before its last
  // bus cycle ends. A held request is then taken on the following ph 1->0
  // edge and starts at once, so exactly GAP_CYCLES idle bus cycles separate
  // two transfers.
  localparam logic [2:0] GAP_INIT_C = 3'(2 * GAP_CYCLES - 2);

  state_t      state_r;
  logic        ph_r;
  logic [1:0]  bc_r;
  logic [2:0]  gcnt_r;
  logic        pend_r;
  logic        ready_r;
  logic        done_r;
  logic [31:0] rsp_r;
  logic        wr_r;
  logic [7:0]  addr_r;
  logic [31:0] data_r;
  logic [7:0]  bus_addr_r;
  logic        re_r;
  logic        we_r;
  logic        ds_r;
  logic        drv_r;
  logic [7:0]  dout_r;

  logic        take_s;
  logic        start_s;
  logic        src_write_s;
  logic [7:0]  src_addr_s;
  logic [31:0] src_data_s;
  logic [1:0]  bc_next_s;

  // Request acceptance and transfer-start decode.
  // A request taken on a ph 1->0 edge starts on that same edge from the live
  // inputs. Otherwise it waits one clock and starts from the captured copy.
  always_comb begin
    take_s      = 1'b0;
    start_s     = 1'b0;
    src_write_s = wr_r;
    src_addr_s  = addr_r;
    src_data_s  = data_r;
    bc_next_s   = bc_r + 2'd1;
    take_s      = (state_r == ST_IDLE) && ready_r && req_valid;
    if (take_s) begin
      src_write_s = req_write;
      src_addr_s  = req_addr;
      src_data_s  = req_data;
    end else begin
      src_write_s = wr_r;
      src_addr_s  = addr_r;
      src_data_s  = data_r;
    end
    start_s = (state_r == ST_IDLE) && ph_r && (take_s || pend_r);
  end

  // Transfer FSM, bus phase and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      ph_r       <= 1'b0;
      bc_r       <= 2'd0;
      gcnt_r     <= 3'd0;
      pend_r     <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      rsp_r      <= 32'd0;
      wr_r       <= 1'b0;
      addr_r     <= 8'd0;
      data_r     <= 32'd0;
      bus_addr_r <= IDLE_ADDR;
      re_r       <= 1'b0;
      we_r       <= 1'b0;
      ds_r       <= 1'b0;
      drv_r      <= 1'b0;
      dout_r     <= 8'd0;
    end else begin
      ph_r   <= ~ph_r;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            wr_r    <= req_write;
            addr_r  <= req_addr;
            data_r  <= req_data;
            ready_r <= 1'b0;
          end
          if (start_s) begin
            state_r    <= ST_XFER;
            pend_r     <= 1'b0;
            bc_r       <= 2'd0;
            bus_addr_r <= src_addr_s;
            re_r       <= ~src_write_s;
            we_r       <= src_write_s;
            ds_r       <= 1'b1;
            drv_r      <= src_write_s;
            dout_r     <= src_data_s[7:0];
          end else if (take_s) begin
            pend_r <= 1'b1;
          end
        end
        ST_XFER: begin
          // ph_r = 1 here means this edge ends the current bus cycle.
          if (ph_r) begin
            if (!wr_r) begin
              rsp_r[{bc_r, 3'b000} +: 8] <= rbusData;
            end
            if (bc_r == 2'd3) begin
              state_r    <= ST_GAP;
              gcnt_r     <= GAP_INIT_C;
              done_r     <= 1'b1;
              bus_addr_r <= IDLE_ADDR;
              re_r       <= 1'b0;
              we_r       <= 1'b0;
              ds_r       <= 1'b0;
              drv_r      <= 1'b0;
            end else begin
              bc_r   <= bc_next_s;
              dout_r <= data_r[{bc_next_s, 3'b000} +: 8];
            end
          end
        end
        ST_GAP: begin
          if (gcnt_r == 3'd0) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
          end else begin
            gcnt_r <= gcnt_r - 3'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pend_r     <= 1'b0;
          ready_r    <= 1'b1;
          bus_addr_r <= IDLE_ADDR;
          re_r       <= 1'b0;
          we_r       <= 1'b0;
          ds_r       <= 1'b0;
          drv_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign done      = done_r;
  assign rsp_data  = rsp_r;
  assign rbusCtrl  = {bus_addr_r, re_r, we_r, ds_r, ph_r};
  assign rbusData  = drv_r ? dout_r : 8'bzzzz_zzzz;

endmodule

// File: doc/wca_rbus_dword_master.md
WCA_RBUS_DWORD_MASTER -- requirements
Module: wca_rbus_dword_master

Interface
REQ-001 Parameter IDLE_ADDR, default 8'hFF: bus address driven when no transfer is active; no slave may use it.
REQ-002 Parameter GAP_CYCLES, default 1: idle bus cycles inserted after every transfer (legal range 1..3).
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_write  input  1  1 = dword write, 0 = dword read.
REQ-007 req_addr  input  8  target register address.
REQ-008 req_data  input  32  write data; ignored for reads.
REQ-009 req_ready  output  1  request accepted when req_valid & req_ready at a clock edge.
REQ-010 done  output  1  one-clock pulse at transfer completion.
REQ-011 rsp_data  output  32  assembled read data; valid when done pulses for a read.
REQ-012 rbusCtrl  output  12  {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}.
REQ-013 rbusData  inout  8  tri-state byte bus; driven only during write bytes.

Function
REQ-014 Internal phase bit ph SHALL toggle every clock; rbusCtrl[0] (clkbus) = ph; a bus cycle is two clocks (ph=0 then ph=1).
REQ-015 rbusCtrl[11:1] and driven rbusData SHALL change only on the clock edge where ph goes 1->0, so they are stable across each clkbus rising edge.
REQ-016 FSM states: IDLE, XFER, GAP.
REQ-017 IDLE: req_ready=1; addr=IDLE_ADDR, readEnable=writeEnable=dataStrobe=0, rbusData hi-Z.
REQ-018 Accepting a request SHALL capture req_write/req_addr/req_data, drop req_ready next clock, and enter XFER at the next bus-cycle boundary (ph 1->0); req_ready=0 outside IDLE.
REQ-019 XFER: 2-bit byte counter bc starts at 0; each bus cycle drives addr=captured addr, dataStrobe=1, writeEnable=req_write, readEnable=~req_write.
REQ-020 Write byte order LSB first: bus cycle bc drives rbusData=data[8*bc+7:8*bc].
REQ-021 Read: rbusData hi-Z; byte sampled on the clock edge ending ph=1 of cycle bc into rsp_data[8*bc+7:8*bc].
REQ-022 bc increments at each bus-cycle boundary; after bc=3 completes FSM SHALL enter GAP.
REQ-023 GAP: outputs as IDLE for GAP_CYCLES bus cycles (guarantees slave byte-select reset), then IDLE.
REQ-024 done SHALL pulse for exactly one clock on entry to GAP; rsp_data holds its value until the next read's first sample.
REQ-025 Total write/read occupancy with GAP_CYCLES=1: acceptance to done <= 10 clocks, to req_ready re-asserted <= 12 clocks.
REQ-026 req_valid deasserted or changed while not ready SHALL be ignored; captured values SHALL not change mid-transfer.
REQ-027 rbusData SHALL never be driven while readEnable=1 or in IDLE/GAP.
REQ-028 Back-to-back requests SHALL always be separated by the GAP cycles; no address may go directly from one target to another.

Reset
REQ-029 reset_n=0 at a clock edge SHALL, on that edge, force IDLE, ph=0, bc=0, req_ready=1, done=0, rsp_data=0, rbusCtrl={IDLE_ADDR,4'b0000}, rbusData hi-Z.
REQ-030 Reset mid-transfer SHALL abort with no done pulse; the partially written dword is not completed.

Verification
REQ-031 Write addr 8'h12 data 32'hA1B2C3D4 -> four strobe cycles with rbusData B: D4,C3,B2,A1, writeEnable=1, then addr 8'hFF, one done pulse.
REQ-032 Read addr 8'h05, model slave returns 11,22,33,44 -> rsp_data=32'h44332211 at done, rbusData never driven by DUT.
REQ-033 Two writes back-to-back (req_valid held) -> exactly GAP_CYCLES bus cycles with addr 8'hFF between them; second accepted only after req_ready returns.
REQ-034 reset_n low during bc=2 of a write -> next clock rbusCtrl=12'hFF0, hi-Z, no done; new request then completes normally.
REQ-035 Request presented at ph=1 vs ph=0 -> transfer starts at the next ph 1->0 boundary; clkbus toggles continuously without glitch.
REQ-036 With a WcaWriteDwordReg-style slave at 8'h12: write 32'hDEADBEEF -> slave out=32'hDEADBEEF; second write 32'h01020304 -> out=32'h01020304.
